// File: rtl/pipe_flow_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_flow_stage
// Purpose  : Parametrised inter-stage pipeline register. Carries one opaque
//            payload between two pipeline stages under the global flow code
//            (WORK / STOP / REFRESH) plus a valid/ready handshake backed by a
//            one-entry skid buffer. Upstream keeps full throughput while
//            downstream back-pressures.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            flow_i            - 0=WORK, 1=STOP, 2/3=REFRESH
//            in_valid_i/in_ready_o/in_data_i    - upstream handshake
//            out_valid_o/out_ready_i/out_data_o - downstream handshake
//            stall_cnt_o, flush_cnt_o           - perf counters (optional)
// Options  : define PIPE_FLOW_STAGE_PERF_EN to add the saturating 16-bit
//            stall and flush counters and their output ports.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_flow_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_VALUE  = {DATA_WIDTH{1'b0}},
    parameter int                    FLOW_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLOW_WIDTH-1:0] flow_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o
`ifdef PIPE_FLOW_STAGE_PERF_EN
    ,
    output logic [15:0]           stall_cnt_o,
    output logic [15:0]           flush_cnt_o
`endif
);

    localparam logic [FLOW_WIDTH-1:0] c_FLOW_WORK = {FLOW_WIDTH{1'b0}};
    localparam logic [FLOW_WIDTH-1:0] c_FLOW_STOP = FLOW_WIDTH'(1);

    logic                  r_main_valid_q, w_main_valid_d;
    logic [DATA_WIDTH-1:0] r_main_data_q,  w_main_data_d;
    logic                  r_skid_valid_q, w_skid_valid_d;
    logic [DATA_WIDTH-1:0] r_skid_data_q,  w_skid_data_d;

    logic w_work;
    logic w_stop;
    logic w_refresh;
    logic w_acc;
    logic w_fire;

    // Every code other than WORK and STOP (including reserved ones) flushes.
    assign w_work    = (flow_i == c_FLOW_WORK);
    assign w_stop    = (flow_i == c_FLOW_STOP);
    assign w_refresh = ~w_work & ~w_stop;

    // Ready depends only on registered skid state, so there is no
    // combinational path from out_ready_i back to in_ready_o.
    assign in_ready_o  = w_work & ~r_skid_valid_q;
    assign out_valid_o = r_main_valid_q & w_work;
    assign out_data_o  = r_main_data_q;

    assign w_acc  = in_valid_i & in_ready_o;
    assign w_fire = out_valid_o & out_ready_i;

    always_comb begin
        w_main_valid_d = r_main_valid_q;
        w_main_data_d  = r_main_data_q;
        w_skid_valid_d = r_skid_valid_q;
        w_skid_data_d  = r_skid_data_q;

        if (w_refresh) begin
            w_main_valid_d = 1'b0;
            w_main_data_d  = NOP_VALUE;
            w_skid_valid_d = 1'b0;
            w_skid_data_d  = NOP_VALUE;
        end else if (w_work) begin
            if (!r_main_valid_q || w_fire) begin
                // Main slot is free this edge; the skid entry is older than
                // anything upstream, so it drains first to keep FIFO order.
                if (r_skid_valid_q) begin
                    w_main_valid_d = 1'b1;
                    w_main_data_d  = r_skid_data_q;
                    w_skid_valid_d = 1'b0;
                end else if (w_acc) begin
                    w_main_valid_d = 1'b1;
                    w_main_data_d  = in_data_i;
                end else begin
                    // Data is deliberately held so out_data_o stays stable.
                    w_main_valid_d = 1'b0;
                end
            end else if (w_acc) begin
                w_skid_valid_d = 1'b1;
                w_skid_data_d  = in_data_i;
            end
        end
        // STOP: everything holds via the defaults above.
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid_q <= 1'b0;
            r_main_data_q  <= NOP_VALUE;
            r_skid_valid_q <= 1'b0;
            r_skid_data_q  <= NOP_VALUE;
        end else begin
            r_main_valid_q <= w_main_valid_d;
            r_main_data_q  <= w_main_data_d;
            r_skid_valid_q <= w_skid_valid_d;
            r_skid_data_q  <= w_skid_data_d;
        end
    end

`ifdef PIPE_FLOW_STAGE_PERF_EN
    logic [15:0] r_stall_cnt_q, w_stall_cnt_d;
    logic [15:0] r_flush_cnt_q, w_flush_cnt_d;

    always_comb begin
        w_stall_cnt_d = r_stall_cnt_q;
        w_flush_cnt_d = r_flush_cnt_q;
        // A refresh cycle is accounted as a flush, not as a stall.
        if (!w_refresh && r_main_valid_q && !w_fire && (r_stall_cnt_q != 16'hFFFF)) begin
            w_stall_cnt_d = r_stall_cnt_q + 16'd1;
        end
        if (w_refresh && (r_main_valid_q || r_skid_valid_q) && (r_flush_cnt_q != 16'hFFFF)) begin
            w_flush_cnt_d = r_flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt_q <= 16'd0;
            r_flush_cnt_q <= 16'd0;
        end else begin
            r_stall_cnt_q <= w_stall_cnt_d;
            r_flush_cnt_q <= w_flush_cnt_d;
        end
    end

    assign stall_cnt_o = r_stall_cnt_q;
    assign flush_cnt_o = r_flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_flow_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_flow_stage
// Purpose  : Self-checking bench for pipe_flow_stage. The stage is modelled
//            as a FIFO of capacity two: a push happens when upstream offers,
//            the flow code is WORK and fewer than two items are held; reset
//            and refresh empty it. The monitor pops on each DUT transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_flow_stage;

    localparam int          c_DW  = 32;
    localparam logic [31:0] c_NOP = 32'h0BAD_F00D;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      flow_i = 2'd0;
    logic            in_valid_i = 1'b0;
    logic            in_ready_o;
    logic [c_DW-1:0] in_data_i = '0;
    logic            out_valid_o;
    logic            out_ready_i = 1'b0;
    logic [c_DW-1:0] out_data_o;

    pipe_flow_stage #(
        .DATA_WIDTH (c_DW),
        .NOP_VALUE  (c_NOP),
        .FLOW_WIDTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flow_i      (flow_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o)
    );

    always #5 clk = ~clk;

    // Reference model state: items held by the stage, oldest first, and the
    // value the output register shows when nothing is held.
    logic [c_DW-1:0] sb_q[$];
    logic [c_DW-1:0] last_data = c_NOP;
    int              errors = 0;
    int              checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive at negedge, model update at posedge.
    task automatic cyc(input logic [1:0] f, input logic v, input logic [31:0] d,
                       input logic r, input logic rs, output logic accepted);
        int occ;
        @(negedge clk);
        flow_i      = f;
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = r;
        rst         = rs;
        occ         = sb_q.size();
        accepted    = !rs && (f == 2'd0) && v && (occ < 2);
        @(posedge clk);
        if (rs || f >= 2'd2) begin
            sb_q.delete();
            last_data = c_NOP;
        end else if (accepted) begin
            sb_q.push_back(d);
        end
    endtask

    // Monitor: checks handshake outputs against the model and pops the
    // expected payload whenever the DUT presents a transfer.
    always begin
        logic [31:0] exp_d;
        logic        work;
        @(negedge clk);
        #1;
        if (!rst) begin
            work = (flow_i == 2'd0);
            chk("in_ready", {31'd0, in_ready_o}, {31'd0, work && sb_q.size() < 2});
            chk("out_valid", {31'd0, out_valid_o}, {31'd0, work && sb_q.size() > 0});
            exp_d = (sb_q.size() > 0) ? sb_q[0] : last_data;
            chk("out_data", out_data_o, exp_d);
            if (out_valid_o && out_ready_i) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_fire", 32'd1, 32'd0);
                end else begin
                    exp_d = sb_q.pop_front();
                    chk("fire_data", out_data_o, exp_d);
                    last_data = exp_d;
                end
            end
        end
    end

    initial begin
        logic        a;
        logic        hold_v;
        logic [31:0] hold_d;
        logic [1:0]  f;
        logic        v, r, rs;
        int          k;

        // Reset for two cycles while upstream offers data, then idle.
        cyc(2'd0, 1'b1, 32'h77, 1'b1, 1'b1, a);
        cyc(2'd0, 1'b1, 32'h77, 1'b1, 1'b1, a);
        cyc(2'd0, 1'b0, 32'h0, 1'b1, 1'b0, a);
        cyc(2'd0, 1'b0, 32'h0, 1'b1, 1'b0, a);

        // Streaming 1..8 at full rate.
        for (int i = 1; i <= 8; i++) cyc(2'd0, 1'b1, i, 1'b1, 1'b0, a);
        cyc(2'd0, 1'b0, 32'h0, 1'b1, 1'b0, a);
        cyc(2'd0, 1'b0, 32'h0, 1'b1, 1'b0, a);

        // Back-pressure: A,B fill main/skid, C waits upstream.
        cyc(2'd0, 1'b1, 32'hA, 1'b1, 1'b0, a);
        cyc(2'd0, 1'b1, 32'hB, 1'b0, 1'b0, a);
        cyc(2'd0, 1'b1, 32'hC, 1'b0, 1'b0, a);
        cyc(2'd0, 1'b1, 32'hC, 1'b0, 1'b0, a);
        cyc(2'd0, 1'b1, 32'hC, 1'b1, 1'b0, a);
        cyc(2'd0, 1'b1, 32'hC, 1'b1, 1'b0, a);
        for (int i = 0; i < 3; i++) cyc(2'd0, 1'b0, 32'h0, 1'b1, 1'b0, a);

        // STOP holds a full stage.
        cyc(2'd0, 1'b1, 32'h55, 1'b0, 1'b0, a);
        cyc(2'd0, 1'b1, 32'h66, 1'b0, 1'b0, a);
        for (int i = 0; i < 3; i++) cyc(2'd1, 1'b1, 32'h77, 1'b1, 1'b0, a);
        for (int i = 0; i < 3; i++) cyc(2'd0, 1'b0, 32'h0, 1'b1, 1'b0, a);

        // REFRESH (code 2, then reserved code 3) with traffic on both sides.
        for (int code = 2; code <= 3; code++) begin
            cyc(2'd0, 1'b1, 32'h100 + code, 1'b0, 1'b0, a);
            cyc(2'd0, 1'b1, 32'h200 + code, 1'b0, 1'b0, a);
            cyc(2'(code), 1'b1, 32'h300, 1'b1, 1'b0, a);
            cyc(2'd0, 1'b0, 32'h0, 1'b1, 1'b0, a);
            cyc(2'd0, 1'b0, 32'h0, 1'b1, 1'b0, a);
        end

        // Randomized traffic; upstream holds an offered payload until taken.
        hold_v = 1'b0;
        hold_d = '0;
        for (int i = 0; i < 4000; i++) begin
            k = $urandom_range(0, 19);
            f = (k < 15) ? 2'd0 : (k < 17) ? 2'd1 : (k < 19) ? 2'd2 : 2'd3;
            r = ($urandom_range(0, 3) != 0);
            if (i % 500 > 400) r = ($urandom_range(0, 4) == 0);
            rs = ($urandom_range(0, 199) == 0);
            if (hold_v) begin
                v = 1'b1;
            end else begin
                v = ($urandom_range(0, 3) != 0);
                hold_d = $urandom;
            end
            cyc(f, v, hold_d, r, rs, a);
            hold_v = v && !a;
        end

        cyc(2'd0, 1'b0, 32'h0, 1'b1, 1'b0, a);
        cyc(2'd0, 1'b0, 32'h0, 1'b1, 1'b0, a);
        cyc(2'd0, 1'b0, 32'h0, 1'b1, 1'b0, a);
        @(negedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_flow_stage.md
Name: pipe_flow_stage

Overview:
Parametrised successor to the fixed-field inter-stage pipeline registers. It carries one opaque payload bus of configurable width between two pipeline stages. It keeps the global flow-control codes (work/stop/refresh) and adds a valid/ready handshake with a one-entry skid buffer, so an upstream stage keeps full throughput while downstream back-pressures. One instance per stage boundary (if/id, id/ex, ex/as, ...). The payload is packed and unpacked by the instantiating top.

Parameters:
DATA_WIDTH, 32, payload width in bits (>=1).
NOP_VALUE, {DATA_WIDTH{1'b0}}, payload value loaded on reset and on refresh (bubble encoding).
FLOW_WIDTH, 2, width of the flow-control code.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset; one clock; reset is synchronous and active-high
flow_i  in  FLOW_WIDTH  0=WORK, 1=STOP, 2=REFRESH, 3=reserved (treated as REFRESH)
in_valid_i  in  1  upstream payload valid
in_ready_o  out  1  stage can accept the upstream payload this cycle
in_data_i  in  DATA_WIDTH  upstream payload
out_valid_o  out  1  output payload valid
out_ready_i  in  1  downstream accepts the payload
out_data_o  out  DATA_WIDTH  registered output payload

Behaviour:
- State: main_valid/main_data (drives the outputs) and skid_valid/skid_data.
- Reset (rst=1 at the edge): main_valid=0, skid_valid=0, main_data=NOP_VALUE, skid_data=NOP_VALUE. Reset overrides flow_i and both handshakes. It is legal mid-transfer; any pending payload is dropped.
- Combinational outputs:
  - in_ready_o = (flow_i==WORK) & ~skid_valid.
  - out_valid_o = main_valid & (flow_i==WORK).
  - out_data_o = main_data, always; it is never masked.
- Accept condition: acc = in_valid_i & in_ready_o.
- Fire condition: fire = out_valid_o & out_ready_i.
- WORK, evaluated at the edge:
  - main empty or fire, skid valid: main<=skid, main_valid=1, skid_valid<=0. Because in_ready_o was 0, no acceptance happens this cycle.
  - main empty or fire, skid empty, acc: main<=in_data_i, main_valid=1.
  - main empty or fire, skid empty, no acc: main_valid<=0 and main_data is held (not cleared).
  - main full and no fire, acc: skid<=in_data_i, skid_valid=1.
  - Net effect: one-cycle latency input-to-output when unstalled, sustained 1 transfer/cycle, and no combinational path from out_ready_i to in_ready_o.
- STOP: all state held, including data. Neither accept nor fire can occur. An upstream payload presented during STOP is not consumed and must be held by upstream.
- REFRESH or code 3: main_valid=0, skid_valid=0, main_data=NOP_VALUE, skid_data=NOP_VALUE. No accept and no fire. Refresh takes priority over a simultaneous in_valid_i/out_ready_i.
- Both entries full with fire: skid moves to main and the stage is left with one entry. Upstream sees in_ready_o=0 in that cycle and 1 in the next.
- Payload ordering is strictly FIFO. Nothing is duplicated or dropped except on reset or refresh.

Optional Feature:
Macro PIPE_FLOW_STAGE_PERF_EN.
- Defined: adds two output ports, stall_cnt_o[15:0] and flush_cnt_o[15:0]. Both are reset to 0 and saturate at 16'hFFFF.
  - stall_cnt_o increments in every cycle where main_valid=1 and fire=0, including STOP cycles.
  - flush_cnt_o increments in every REFRESH cycle (code 2 or 3) in which main_valid or skid_valid is 1.
- Undefined: neither port nor counter exists, and all other behaviour is identical.

Test Plan:
1. Reset and idle: assert rst for 2 cycles with in_valid_i=1 -> out_valid_o=0, in_ready_o=1 once released, out_data_o=NOP_VALUE (e.g. 0).
2. Streaming: WORK, out_ready_i=1, in_data 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8, each one cycle later, 8 fires in 8 cycles, in_ready_o constant 1.
3. Back-pressure: stream 0xA,0xB,0xC with out_ready_i=0 from cycle 1 -> main=0xA, skid=0xB, in_ready_o=0, 0xC held upstream. Then out_ready_i=1 -> outputs 0xA,0xB,0xC in order with no loss.
4. STOP hold: with main=0x55 and skid=0x66, hold flow_i=STOP for 3 cycles with out_ready_i=1 -> out_valid_o=0, in_ready_o=0, state unchanged. Return to WORK -> 0x55 then 0x66.
5. REFRESH with simultaneous traffic: main and skid full, flow_i=REFRESH, in_valid_i=1, out_ready_i=1 -> next cycle both valids 0, out_data_o=NOP_VALUE, nothing fired or accepted. Repeat with code 3 -> same result.
6. PERF (macro defined): 4 stalled cycles then one REFRESH with main valid -> stall_cnt_o=4, flush_cnt_o=1. Force 70000 stall cycles -> stall_cnt_o stays at 16'hFFFF.
